fm_spi_slave: RTL and testbench

//  SPI responder (slave) for the flash-memory SPI bus; the far end of the mode0/mode3 master in FlashMemoryControlBlock.

---
 rtl/fm_spi_slave.sv | 221 ++++++++++++++++++++++
 tb/tb_fm_spi_slave.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_spi_slave.sv
// SPI responder for the flash-memory SPI bus.
// CS/SCK/MOSI are oversampled in the iSysClk domain; MOSI is deserialised
// into bytes and MISO is serialised MSB first from a one-byte holding buffer.
// SCK must be at most 1/8 of iSysClk.
module fm_spi_slave #(
    parameter string      pMode    = "mode0",
    parameter int         pSyncStg = 2,
    parameter logic [7:0] pDummy   = 8'hFF
) (
    input  logic       iSysClk,
    input  logic       iSysRst,
    input  logic       iCs,
    input  logic       iSck,
    input  logic       iMosi,
    output logic       oMiso,
    output logic       oMisoOe,
    input  logic [7:0] iWd,
    input  logic       iWdVd,
    output logic       oWdReq,
    output logic [7:0] oRd,
    output logic       oRdVd,
    output logic       oUnderrun,
    output logic       oBusy
);

    localparam logic IS_MODE3 = (pMode == "mode3") ? 1'b1 : 1'b0;
    localparam logic SCK_IDLE = IS_MODE3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Synchroniser chains and edge-detect history
    logic [pSyncStg-1:0] cs_sync_q;
    logic [pSyncStg-1:0] sck_sync_q;
    logic [pSyncStg-1:0] mosi_sync_q;
    logic                cs_prev_q;
    logic                sck_prev_q;

    // Transfer state
    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic       lead_q;
    logic [7:0] rx_q;
    logic [7:0] tx_q;
    logic [7:0] tx_d;
    logic [7:0] buf_q;
    logic       wd_req_q;

    // Registered outputs
    logic       miso_q;
    logic       miso_oe_q;
    logic [7:0] rd_q;
    logic       rd_vd_q;
    logic       underrun_q;
    logic       busy_q;

    // Combinational qualifiers
    logic       cs_now_s;
    logic       sck_now_s;
    logic       mosi_now_s;
    logic       cs_fall_s;
    logic       cs_rise_s;
    logic       sck_fall_s;
    logic       sck_rise_s;
    logic       start_s;
    logic       stop_s;
    logic       rx_edge_s;
    logic       tx_edge_s;
    logic       reload_s;
    logic       shift_s;
    logic       wd_accept_s;
    logic [7:0] load_byte_s;
    logic [7:0] rx_d;

    // Synchronise the SPI inputs and keep one cycle of history for edge detection.
    // CS resets to its active level so a CS held low across reset never looks
    // like a fresh assertion: a new transfer needs a real high-to-low toggle.
    always_ff @(posedge iSysClk) begin
        if (iSysRst) begin
            cs_sync_q   <= '0;
            sck_sync_q  <= {pSyncStg{SCK_IDLE}};
            mosi_sync_q <= '1;
            cs_prev_q   <= 1'b0;
            sck_prev_q  <= SCK_IDLE;
        end else begin
            cs_sync_q   <= {cs_sync_q[pSyncStg-2:0], iCs};
            sck_sync_q  <= {sck_sync_q[pSyncStg-2:0], iSck};
            mosi_sync_q <= {mosi_sync_q[pSyncStg-2:0], iMosi};
            cs_prev_q   <= cs_now_s;
            sck_prev_q  <= sck_now_s;
        end
    end

    // Edge qualifiers and the shift/reload decisions for this cycle
    always_comb begin
        cs_now_s    = cs_sync_q[pSyncStg-1];
        sck_now_s   = sck_sync_q[pSyncStg-1];
        mosi_now_s  = mosi_sync_q[pSyncStg-1];
        cs_fall_s   = cs_prev_q & ~cs_now_s;
        cs_rise_s   = ~cs_prev_q & cs_now_s;
        sck_fall_s  = sck_prev_q & ~sck_now_s;
        sck_rise_s  = ~sck_prev_q & sck_now_s;
        // SCK edges only count inside an active transfer; a CS release wins
        start_s     = (state_q == ST_IDLE) & cs_fall_s;
        stop_s      = (state_q == ST_ACTIVE) & cs_rise_s;
        rx_edge_s   = (state_q == ST_ACTIVE) & ~cs_rise_s & sck_rise_s;
        tx_edge_s   = (state_q == ST_ACTIVE) & ~cs_rise_s & sck_fall_s & ~lead_q;
        reload_s    = start_s | (tx_edge_s & (bit_cnt_q == 3'd0));
        shift_s     = tx_edge_s & (bit_cnt_q != 3'd0);
        wd_accept_s = iWdVd & wd_req_q;
        rx_d        = {rx_q[6:0], mosi_now_s};
        if (wd_req_q) begin
            load_byte_s = pDummy;
        end else begin
            load_byte_s = buf_q;
        end
        if (reload_s) begin
            tx_d = load_byte_s;
        end else if (shift_s) begin
            tx_d = {tx_q[6:0], 1'b1};
        end else begin
            tx_d = tx_q;
        end
    end

    // Transfer FSM, shifters, holding buffer and registered outputs
    always_ff @(posedge iSysClk) begin
        if (iSysRst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            lead_q     <= 1'b0;
            rx_q       <= 8'h00;
            tx_q       <= pDummy;
            buf_q      <= 8'h00;
            wd_req_q   <= 1'b1;
            miso_q     <= 1'b1;
            miso_oe_q  <= 1'b0;
            rd_q       <= 8'h00;
            rd_vd_q    <= 1'b0;
            underrun_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rd_vd_q <= 1'b0;
            tx_q    <= tx_d;
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        state_q    <= ST_ACTIVE;
                        bit_cnt_q  <= 3'd0;
                        lead_q     <= IS_MODE3;
                        miso_q     <= tx_d[7];
                        miso_oe_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        underrun_q <= wd_req_q;
                    end else begin
                        miso_q    <= 1'b1;
                        miso_oe_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (stop_s) begin
                        // Partial byte is dropped; the holding buffer is kept
                        state_q   <= ST_IDLE;
                        bit_cnt_q <= 3'd0;
                        lead_q    <= 1'b0;
                        miso_q    <= 1'b1;
                        miso_oe_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else begin
                        miso_q <= tx_d[7];
                        if (rx_edge_s) begin
                            rx_q      <= rx_d;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            lead_q    <= 1'b0;
                            if (bit_cnt_q == 3'd7) begin
                                rd_q    <= rx_d;
                                rd_vd_q <= 1'b1;
                            end else begin
                                rd_q <= rd_q;
                            end
                        end else begin
                            rx_q <= rx_q;
                        end
                        if (reload_s && wd_req_q) begin
                            underrun_q <= 1'b1;
                        end else begin
                            underrun_q <= underrun_q;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    miso_q    <= 1'b1;
                    miso_oe_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
            // A reload consumes the old buffer state before a same-cycle write lands
            if (wd_accept_s) begin
                buf_q    <= iWd;
                wd_req_q <= 1'b0;
            end else if (reload_s) begin
                wd_req_q <= 1'b1;
            end else begin
                wd_req_q <= wd_req_q;
            end
        end
    end

    assign oMiso     = miso_q;
    assign oMisoOe   = miso_oe_q;
    assign oWdReq    = wd_req_q;
    assign oRd       = rd_q;
    assign oRdVd     = rd_vd_q;
    assign oUnderrun = underrun_q;
    assign oBusy     = busy_q;

endmodule

// File: tb/tb_fm_spi_slave.sv
// Directed bench for fm_spi_slave: one mode0 and one mode3 instance,
// a table of single-byte transfers plus hand-written multi-cycle sequences.
module tb_fm_spi_slave;

    localparam int HALF = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       mosi;
    logic [7:0] wd;
    logic       cs0, sck0, wdvd0, cs3, sck3, wdvd3;
    logic       miso0, oe0, wdreq0, rdvd0, urun0, busy0;
    logic       miso3, oe3, wdreq3, rdvd3, urun3, busy3;
    logic [7:0] rd0, rd3;

    fm_spi_slave #(.pMode("mode0"), .pSyncStg(2), .pDummy(8'hFF)) dut0 (
        .iSysClk(clk), .iSysRst(rst), .iCs(cs0), .iSck(sck0), .iMosi(mosi),
        .oMiso(miso0), .oMisoOe(oe0), .iWd(wd), .iWdVd(wdvd0), .oWdReq(wdreq0),
        .oRd(rd0), .oRdVd(rdvd0), .oUnderrun(urun0), .oBusy(busy0));

    fm_spi_slave #(.pMode("mode3"), .pSyncStg(2), .pDummy(8'hFF)) dut3 (
        .iSysClk(clk), .iSysRst(rst), .iCs(cs3), .iSck(sck3), .iMosi(mosi),
        .oMiso(miso3), .oMisoOe(oe3), .iWd(wd), .iWdVd(wdvd3), .oWdReq(wdreq3),
        .oRd(rd3), .oRdVd(rdvd3), .oUnderrun(urun3), .oBusy(busy3));

    // Selected instance
    logic       m3 = 1'b0;
    logic       miso_m, oe_m, wdreq_m, rdvd_m, urun_m, busy_m;
    logic [7:0] rd_m;
    assign miso_m  = m3 ? miso3  : miso0;
    assign oe_m    = m3 ? oe3    : oe0;
    assign wdreq_m = m3 ? wdreq3 : wdreq0;
    assign rdvd_m  = m3 ? rdvd3  : rdvd0;
    assign urun_m  = m3 ? urun3  : urun0;
    assign busy_m  = m3 ? busy3  : busy0;
    assign rd_m    = m3 ? rd3    : rd0;

    int n_chk = 0;
    int n_err = 0;

    // Count oRdVd pulses of the selected instance and remember the byte
    int         rdvd_total = 0;
    logic [7:0] last_rd = 8'h00;
    always @(negedge clk) begin
        if (rdvd_m) begin
            rdvd_total = rdvd_total + 1;
            last_rd    = rd_m;
        end
    end

    typedef struct {
        logic       mode3;
        logic       pre_vld;
        logic [7:0] pre;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_rd;
        logic       exp_urun;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_cs(input logic v);
        if (m3) cs3 = v; else cs0 = v;
    endtask

    task automatic set_sck(input logic v);
        if (m3) sck3 = v; else sck0 = v;
    endtask

    task automatic set_wdvd(input logic v);
        if (m3) wdvd3 = v; else wdvd0 = v;
    endtask

    task automatic write_buf(input logic [7:0] d);
        int k = 0;
        while (!wdreq_m && k < 64) begin
            tick(1);
            k = k + 1;
        end
        chk("wdreq_wait", wdreq_m, 8'd1);
        wd = d;
        set_wdvd(1'b1);
        tick(1);
        set_wdvd(1'b0);
        chk("wdreq_after_load", wdreq_m, 8'd0);
    endtask

    task automatic cs_low();
        set_cs(1'b0);
        tick(HALF);
    endtask

    task automatic cs_high();
        tick(2);
        set_cs(1'b1);
        tick(HALF);
    endtask

    // Master side: drive nbits of tx MSB first, capture MISO before each rising SCK
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (m3) set_sck(1'b0);
            mosi = tx[i];
            tick(HALF);
            rx[i] = miso_m;
            set_sck(1'b1);
            tick(HALF);
            if (!m3) set_sck(1'b0);
        end
        if (!m3) tick(HALF);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_miso"}, miso_m, 8'd1);
        chk({nm, "_oe"}, oe_m, 8'd0);
        chk({nm, "_wdreq"}, wdreq_m, 8'd1);
        chk({nm, "_rd"}, rd_m, 8'h00);
        chk({nm, "_rdvd"}, rdvd_m, 8'd0);
        chk({nm, "_urun"}, urun_m, 8'd0);
        chk({nm, "_busy"}, busy_m, 8'd0);
    endtask

    initial begin
        logic [7:0] rx;
        int         base;

        rst = 1'b1; mosi = 1'b1; wd = 8'h00;
        cs0 = 1'b1; sck0 = 1'b0; wdvd0 = 1'b0;
        cs3 = 1'b1; sck3 = 1'b1; wdvd3 = 1'b0;
        tick(4);
        m3 = 1'b0; #1; chk_reset("reset0");
        m3 = 1'b1; #1; chk_reset("reset3");
        rst = 1'b0;
        tick(4);

        //          mode3 pre_vld pre    mosi   miso   rd     urun
        tbl[0] = '{1'b0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 8'h00, 8'h5A, 8'hFF, 8'h5A, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 8'h81, 8'hC3, 8'h81, 8'hC3, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 8'h00, 8'hF0, 8'hFF, 8'hF0, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b0};

        for (int i = 0; i < 5; i++) begin
            m3 = tbl[i].mode3;
            tick(1);
            if (tbl[i].pre_vld) write_buf(tbl[i].pre);
            base = rdvd_total;
            cs_low();
            chk("vec_oe_active", oe_m, 8'd1);
            chk("vec_busy_active", busy_m, 8'd1);
            chk("vec_urun_start", urun_m, {7'd0, tbl[i].exp_urun});
            spi_bits(tbl[i].mosi, 8, rx);
            chk("vec_miso_byte", rx, tbl[i].exp_miso);
            chk("vec_rdvd_count", 8'(rdvd_total - base), 8'd1);
            chk("vec_rd", last_rd, tbl[i].exp_rd);
            chk("vec_rd_port", rd_m, tbl[i].exp_rd);
            cs_high();
            chk("vec_oe_idle", oe_m, 8'd0);
            chk("vec_miso_idle", miso_m, 8'd1);
            chk("vec_busy_idle", busy_m, 8'd0);
        end

        // Three-byte burst with refills between bytes
        m3 = 1'b0;
        tick(1);
        base = rdvd_total;
        cs_low();
        chk("burst_urun_first", urun_m, 8'd1);
        write_buf(8'hEF);
        spi_bits(8'h9F, 8, rx);
        chk("burst_b0_miso", rx, 8'hFF);
        write_buf(8'h40);
        spi_bits(8'h00, 8, rx);
        chk("burst_b1_miso", rx, 8'hEF);
        spi_bits(8'h00, 8, rx);
        chk("burst_b2_miso", rx, 8'h40);
        chk("burst_rdvd_count", 8'(rdvd_total - base), 8'd3);
        chk("burst_rd_last", last_rd, 8'h00);
        chk("burst_urun", urun_m, 8'd1);
        cs_high();

        // CS released after 5 bits, then a clean transfer
        base = rdvd_total;
        cs_low();
        spi_bits(8'hB7, 5, rx);
        chk("abort_miso_bits", rx, 8'hF8);
        cs_high();
        chk("abort_rdvd_count", 8'(rdvd_total - base), 8'd0);
        chk("abort_oe", oe_m, 8'd0);
        chk("abort_miso_idle", miso_m, 8'd1);
        write_buf(8'h96);
        cs_low();
        spi_bits(8'h5A, 8, rx);
        chk("after_abort_miso", rx, 8'h96);
        chk("after_abort_rdvd", 8'(rdvd_total - base), 8'd1);
        chk("after_abort_rd", last_rd, 8'h5A);
        cs_high();

        // Empty buffer for two bytes; underrun sticks until the next CS assert
        cs_low();
        spi_bits(8'h11, 8, rx);
        chk("empty_b0_miso", rx, 8'hFF);
        spi_bits(8'h22, 8, rx);
        chk("empty_b1_miso", rx, 8'hFF);
        cs_high();
        chk("urun_sticky_a", urun_m, 8'd1);
        tick(4);
        chk("urun_sticky_b", urun_m, 8'd1);
        write_buf(8'h3C);
        set_cs(1'b0);
        tick(HALF);
        chk("urun_cleared", urun_m, 8'd0);
        chk("urun_cleared_miso", miso_m, 8'd0);
        cs_high();

        // Reset in the middle of a byte
        cs_low();
        chk("rst_pre_urun", urun_m, 8'd1);
        spi_bits(8'hA5, 3, rx);
        rst = 1'b1;
        tick(1);
        chk_reset("midrst");
        rst = 1'b0;
        base = rdvd_total;
        spi_bits(8'hFF, 8, rx);
        chk("midrst_rdvd_count", 8'(rdvd_total - base), 8'd0);
        chk("midrst_busy", busy_m, 8'd0);
        chk("midrst_oe", oe_m, 8'd0);
        cs_high();
        write_buf(8'hC3);
        cs_low();
        spi_bits(8'hE1, 8, rx);
        chk("post_rst_miso", rx, 8'hC3);
        chk("post_rst_rdvd", 8'(rdvd_total - base), 8'd1);
        chk("post_rst_rd", last_rd, 8'hE1);
        cs_high();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
